// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and FSM state definitions for the RPN evaluator.
package rpn_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_UNDER = 2'b01,
    ERR_OVER  = 2'b10,
    ERR_LEFT  = 2'b11
  } err_t;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    PUSH,
    POP_B,
    WAIT_B,
    POP_A,
    WAIT_A,
    EXEC,
    FINAL_POP,
    FINAL_WAIT,
    SKIP,
    DRAIN,
    REPORT
  } state_t;

endpackage

// File: rtl/rpn_stack_master_alu.sv
// Combinational binary operator unit; all results wrap modulo 2^WORD_LEN.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WORD_LEN = 8
) (
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  input  op_t                 op,
  output logic [WORD_LEN-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_master.sv
// Postfix expression evaluator driving push/pop pulses into an external LIFO
// and reporting one result (or error code) per expression.
module rpn_stack_master
  import rpn_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int WORD_LEN    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tok_valid,
  output logic                tok_ready,
  input  logic                tok_is_op,
  input  logic [WORD_LEN-1:0] tok_data,
  input  logic                tok_last,
  output logic                stk_push,
  output logic                stk_pop,
  output logic [WORD_LEN-1:0] stk_wdata,
  input  logic [WORD_LEN-1:0] stk_rdata,
  input  logic                stk_full,
  input  logic                stk_empty,
  output logic                res_valid,
  output logic [WORD_LEN-1:0] res_data,
  output logic [1:0]          res_err
);

  if (STACK_DEPTH < 1 || WORD_LEN < 2) begin : g_param_guard
    $fatal(1, "rpn_stack_master: STACK_DEPTH must be >= 1 and WORD_LEN >= 2");
  end

  state_t              state;
  err_t                err;
  logic [WORD_LEN-1:0] tok_data_q;
  logic                tok_last_q;
  logic [WORD_LEN-1:0] opnd_b;
  logic [WORD_LEN-1:0] result;
  logic [WORD_LEN-1:0] alu_res;

  // Operand a is the word arriving on stk_rdata in EXEC; b was latched earlier.
  rpn_alu #(.WORD_LEN(WORD_LEN)) u_alu (
    .a      (stk_rdata),
    .b      (opnd_b),
    .op     (op_t'(tok_data_q[1:0])),
    .result (alu_res)
  );

  // Pulses are registered, so stk_rdata for a pop is sampled two states after
  // the pop decision; b is latched in POP_A and a consumed in EXEC.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      err        <= ERR_NONE;
      tok_ready  <= 1'b0;
      stk_push   <= 1'b0;
      stk_pop    <= 1'b0;
      stk_wdata  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= '0;
      tok_data_q <= '0;
      tok_last_q <= 1'b0;
      opnd_b     <= '0;
      result     <= '0;
    end else begin
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE, FETCH: begin
          if (tok_valid && tok_ready) begin
            tok_data_q <= tok_data;
            tok_last_q <= tok_last;
            tok_ready  <= 1'b0;
            state      <= tok_is_op ? POP_B : PUSH;
          end else begin
            tok_ready <= 1'b1;
          end
        end
        PUSH: begin
          if (stk_full) begin
            err       <= ERR_OVER;
            tok_ready <= !tok_last_q;
            state     <= tok_last_q ? DRAIN : SKIP;
          end else begin
            stk_push  <= 1'b1;
            stk_wdata <= tok_data_q;
            tok_ready <= !tok_last_q;
            state     <= tok_last_q ? FINAL_POP : FETCH;
          end
        end
        POP_B: begin
          if (stk_empty) begin
            err       <= ERR_UNDER;
            tok_ready <= !tok_last_q;
            state     <= tok_last_q ? DRAIN : SKIP;
          end else begin
            stk_pop <= 1'b1;
            state   <= WAIT_B;
          end
        end
        WAIT_B: state <= POP_A;
        POP_A: begin
          opnd_b <= stk_rdata;
          if (stk_empty) begin
            err       <= ERR_UNDER;
            tok_ready <= !tok_last_q;
            state     <= tok_last_q ? DRAIN : SKIP;
          end else begin
            stk_pop <= 1'b1;
            state   <= WAIT_A;
          end
        end
        WAIT_A: state <= EXEC;
        EXEC: begin
          stk_push  <= 1'b1;
          stk_wdata <= alu_res;
          tok_ready <= !tok_last_q;
          state     <= tok_last_q ? FINAL_POP : FETCH;
        end
        FINAL_POP: begin
          // Entered with the last push still in flight, which guarantees a word.
          if (!stk_push && stk_empty) begin
            err   <= ERR_UNDER;
            state <= REPORT;
          end else begin
            stk_pop <= 1'b1;
            state   <= FINAL_WAIT;
          end
        end
        FINAL_WAIT: begin
          if (!stk_pop) begin
            result <= stk_rdata;
            if (!stk_empty) begin
              err   <= ERR_LEFT;
              state <= DRAIN;
            end else begin
              state <= REPORT;
            end
          end
        end
        SKIP: begin
          if (tok_valid && tok_ready && tok_last) begin
            tok_ready <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stk_pop) begin
            if (stk_empty) state <= REPORT;
            else stk_pop <= 1'b1;
          end
        end
        REPORT: begin
          res_valid <= 1'b1;
          res_data  <= (err == ERR_NONE) ? result : '0;
          res_err   <= err;
          err       <= ERR_NONE;
          tok_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          tok_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_master.sv
// Directed bench for rpn_stack_master with a behavioural 8-deep LIFO attached.
module tb_rpn_stack_master;

  localparam int WL    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_op = 1'b0;
  logic [WL-1:0] tok_data = '0;
  logic          tok_last = 1'b0;
  logic          stk_push, stk_pop;
  logic [WL-1:0] stk_wdata;
  logic [WL-1:0] stk_rdata;
  logic          stk_full, stk_empty;
  logic          res_valid;
  logic [WL-1:0] res_data;
  logic [1:0]    res_err;

  int checks = 0;
  int fails  = 0;
  int res_cnt = 0, pop_cnt = 0, push_full_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  rpn_stack_master #(.STACK_DEPTH(DEPTH), .WORD_LEN(WL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .tok_last  (tok_last),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  // Stack block: synchronous reset, read data registered on pop.
  logic [WL-1:0] mem [DEPTH];
  logic [3:0]    sp;
  assign stk_full  = (sp == 4'(DEPTH));
  assign stk_empty = (sp == 4'd0);

  always @(posedge clk) begin
    if (!rstn) begin
      sp        <= 4'd0;
      stk_rdata <= '0;
    end else if (stk_push && !stk_full) begin
      mem[sp[2:0]] <= stk_wdata;
      sp           <= sp + 4'd1;
    end else if (stk_pop && !stk_empty) begin
      stk_rdata <= mem[3'(sp - 4'd1)];
      sp        <= sp - 4'd1;
    end
  end

  always @(posedge clk) begin
    if (res_valid) res_cnt++;
    if (stk_pop) pop_cnt++;
    if (stk_push && stk_full) push_full_cnt++;
    if (stk_push && stk_pop) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_tok(input logic is_op, input logic [WL-1:0] data, input logic last);
    int n = 0;
    while (!tok_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("tok_ready_timeout", 32'(tok_ready), 32'd1);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = data;
    tok_last  = last;
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0;
    tok_last  = 1'b0;
  endtask

  task automatic opnd(input logic [WL-1:0] v, input logic last);
    send_tok(1'b0, v, last);
  endtask

  task automatic oper(input logic [1:0] op, input logic last);
    send_tok(1'b1, {6'd0, op}, last);
  endtask

  task automatic wait_result(input string tag, input logic [WL-1:0] exp_data,
                             input logic [1:0] exp_err, input int exp_cnt);
    int n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check({tag, "_err"}, 32'(res_err), 32'(exp_err));
    check({tag, "_empty"}, 32'(stk_empty), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 32'(res_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $error("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench stopped by time limit");
  end

  initial begin
    int p0;
    int r0;
    repeat (3) @(negedge clk);
    check("rst_tok_ready", 32'(tok_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_push", 32'(stk_push), 32'd0);
    check("rst_pop", 32'(stk_pop), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_wdata", 32'(stk_wdata), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(tok_ready), 32'd1);

    // 3 4 + 2 * = 14
    opnd(8'd3, 0); opnd(8'd4, 0); oper(2'b00, 0); opnd(8'd2, 0); oper(2'b10, 1);
    wait_result("expr_mix", 8'd14, 2'b00, 1);

    // 5 7 - wraps to 0xFE; 16 16 * wraps to 0x00
    opnd(8'd5, 0); opnd(8'd7, 0); oper(2'b01, 1);
    wait_result("expr_sub", 8'hFE, 2'b00, 2);
    opnd(8'd16, 0); opnd(8'd16, 0); oper(2'b10, 1);
    wait_result("expr_mulwrap", 8'h00, 2'b00, 3);

    // Underflow on second pop, error token is last
    opnd(8'd1, 0); oper(2'b00, 1);
    wait_result("under_a", 8'd0, 2'b01, 4);

    // Underflow on first pop, remaining tokens discarded
    oper(2'b10, 0); opnd(8'd3, 0); opnd(8'd4, 0); oper(2'b00, 1);
    wait_result("under_skip", 8'd0, 2'b01, 5);

    // Underflow mid-expression after a pop already happened
    opnd(8'd1, 0); oper(2'b00, 0); opnd(8'd5, 1);
    wait_result("under_mid", 8'd0, 2'b01, 6);

    // Overflow: 9 operands into an 8-deep stack
    for (int i = 1; i <= 9; i++) opnd(8'(i), (i == 9));
    wait_result("over", 8'd0, 2'b10, 7);
    opnd(8'd2, 0); opnd(8'd3, 0); oper(2'b00, 1);
    wait_result("after_over", 8'd5, 2'b00, 8);

    // Leftover operand: one final pop plus exactly one drain pop
    p0 = pop_cnt;
    opnd(8'd1, 0); opnd(8'd2, 1);
    wait_result("left", 8'd0, 2'b11, 9);
    check("left_pops", 32'(pop_cnt - p0), 32'd2);
    opnd(8'd6, 0); opnd(8'd6, 0); oper(2'b10, 1);
    wait_result("after_left", 8'd36, 2'b00, 10);

    // Reset mid-expression aborts silently
    opnd(8'd1, 0); opnd(8'd2, 0); opnd(8'd3, 0);
    r0 = res_cnt;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(tok_ready), 32'd1);
    check("midrst_empty", 32'(stk_empty), 32'd1);
    repeat (10) @(negedge clk);
    check("midrst_no_result", 32'(res_cnt), 32'(r0));
    opnd(8'd8, 0); opnd(8'd2, 0); oper(2'b11, 1);
    wait_result("after_rst", 8'd10, 2'b00, r0 + 1);

    check("push_while_full", 32'(push_full_cnt), 32'd0);
    check("push_pop_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
